// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and types for the instruction/data memory port arbiter.
// Source IDs double as the 1-bit tags stored in the response-routing FIFO.
package mem_bus_arbiter_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_HOLD_INST = 2'd1,
        ARB_HOLD_DATA = 2'd2
    } arb_state_t;

    typedef logic [1:0] size_t;

    function automatic arb_state_t hold_state(input logic src);
        return (src == SRC_DATA) ? ARB_HOLD_DATA : ARB_HOLD_INST;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// SRAM-like request/response bundle; master drives the request, slave answers.
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    logic        req;
    logic        wr;
    size_t       size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/arb_id_fifo.sv
// In-order 1-bit tag FIFO recording which master owns each outstanding request.
// Head is read combinationally so responses can be routed in the same cycle.
module arb_id_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          id_mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign head    = id_mem[rd_ptr_reg];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            id_mem[wr_ptr_reg] <= push_id;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data masters.
// Data has priority; a stalled address phase locks the grant until accepted.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_bus_arbiter_if.slave        inst,
    mem_bus_arbiter_if.slave        data,
    mem_bus_arbiter_if.master       s,
    output logic                    resp_err
);
    arb_state_t state_reg;
    arb_state_t state_next;
    logic       sel;
    logic       sel_req;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    logic       resp_valid;
    logic       resp_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A full FIFO blocks new grants even if a response pops this cycle.
    always_comb begin
        sel        = SRC_DATA;
        sel_req    = 1'b0;
        state_next = ARB_IDLE;
        fifo_push  = 1'b0;
        case (state_reg)
            ARB_HOLD_INST: begin
                sel     = SRC_INST;
                sel_req = inst.req;
            end
            ARB_HOLD_DATA: begin
                sel     = SRC_DATA;
                sel_req = data.req;
            end
            default: begin
                if (!fifo_full) begin
                    if (data.req) begin
                        sel     = SRC_DATA;
                        sel_req = 1'b1;
                    end else if (inst.req) begin
                        sel     = SRC_INST;
                        sel_req = 1'b1;
                    end
                end
            end
        endcase
        if (sel_req) begin
            if (s.addr_ok) begin
                fifo_push = 1'b1;
            end else begin
                state_next = hold_state(sel);
            end
        end
    end

    always_comb begin
        s.req   = sel_req;
        s.wr    = (sel == SRC_DATA) ? data.wr    : inst.wr;
        s.size  = (sel == SRC_DATA) ? data.size  : inst.size;
        s.wstrb = (sel == SRC_DATA) ? data.wstrb : inst.wstrb;
        s.addr  = (sel == SRC_DATA) ? data.addr  : inst.addr;
        s.wdata = (sel == SRC_DATA) ? data.wdata : inst.wdata;
    end

    assign inst.addr_ok = s.addr_ok & sel_req & (sel == SRC_INST);
    assign data.addr_ok = s.addr_ok & sel_req & (sel == SRC_DATA);

    assign resp_valid   = s.data_ok & ~fifo_empty;
    assign fifo_pop     = resp_valid;
    assign inst.data_ok = resp_valid & (fifo_head == SRC_INST);
    assign data.data_ok = resp_valid & (fifo_head == SRC_DATA);
    assign inst.rdata   = s.rdata;
    assign data.rdata   = s.rdata;

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .push_id (sel),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    // An orphan response means the slave and arbiter lost sync; latch it.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_err_reg <= 1'b0;
        end else if (s.data_ok && fifo_empty) begin
            resp_err_reg <= 1'b1;
        end
    end

    assign resp_err = resp_err_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter with a queue-based reference
// model; the driver pushes expectations and an independent monitor checks them.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic reset;
    logic resp_err;

    always #5 clk = ~clk;

    mem_bus_arbiter_if inst_bus ();
    mem_bus_arbiter_if data_bus ();
    mem_bus_arbiter_if s_bus ();

    mem_bus_arbiter #(
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .inst     (inst_bus),
        .data     (data_bus),
        .s        (s_bus),
        .resp_err (resp_err)
    );

    typedef struct {
        bit         chk;
        bit         s_req;
        logic [70:0] fields;
        bit         iok;
        bit         dok;
        bit         err;
    } cyc_t;

    typedef struct {
        bit          id;
        logic [31:0] rdata;
    } rsp_t;

    cyc_t cyc_q[$];
    rsp_t rsp_q[$];
    bit   out_q[$];     // owners of accepted-but-unanswered requests, oldest first
    int   lock;         // 0 = free, 1 = locked to inst, 2 = locked to data
    bit   err_m;
    int   errors = 0;
    int   checks = 0;
    bit   ia, da;

    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_master(input bit is_data, input logic [31:0] a, input bit w);
        if (is_data) begin
            data_bus.addr  = a;
            data_bus.wr    = w;
            data_bus.size  = 2'($urandom_range(0, 2));
            data_bus.wstrb = 4'($urandom);
            data_bus.wdata = $urandom;
        end else begin
            inst_bus.addr  = a;
            inst_bus.wr    = w;
            inst_bus.size  = 2'd2;
            inst_bus.wstrb = 4'($urandom);
            inst_bus.wdata = $urandom;
        end
    endtask

    // Drive one cycle of inputs, record what the model predicts, advance the model.
    task automatic cycle(input bit ireq, input bit dreq, input bit aok, input bit dok,
                         input logic [31:0] rd, output bit iacc, output bit dacc);
        cyc_t c;
        rsp_t r;
        bit   win;
        bit   valid;
        inst_bus.req   = ireq;
        data_bus.req   = dreq;
        s_bus.addr_ok  = aok;
        s_bus.data_ok  = dok;
        s_bus.rdata    = rd;
        valid = 1'b0;
        win   = 1'b1;
        if (lock == 1) begin
            win = 1'b0; valid = ireq;
        end else if (lock == 2) begin
            win = 1'b1; valid = dreq;
        end else if (out_q.size() < MAXO) begin
            if (dreq) begin
                win = 1'b1; valid = 1'b1;
            end else if (ireq) begin
                win = 1'b0; valid = 1'b1;
            end
        end
        c.chk    = (reset == 1'b0);
        c.s_req  = valid;
        c.fields = win ? {data_bus.wr, data_bus.size, data_bus.wstrb, data_bus.addr, data_bus.wdata}
                       : {inst_bus.wr, inst_bus.size, inst_bus.wstrb, inst_bus.addr, inst_bus.wdata};
        c.iok    = valid && aok && !win;
        c.dok    = valid && aok && win;
        c.err    = err_m;
        cyc_q.push_back(c);
        if (dok) begin
            if (out_q.size() > 0) begin
                r.id    = out_q.pop_front();
                r.rdata = rd;
                rsp_q.push_back(r);
            end else begin
                err_m = 1'b1;
            end
        end
        if (valid && aok) out_q.push_back(win);
        lock = (valid && !aok) ? (win ? 2 : 1) : 0;
        iacc = c.iok;
        dacc = c.dok;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, ia, da);
        reset = 1'b0;
        out_q.delete();
        rsp_q.delete();
        lock  = 0;
        err_m = 1'b0;
    endtask

    initial begin : monitor
        cyc_t c;
        rsp_t r;
        forever begin
            @(negedge clk);
            #2;
            if (cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                if (c.chk) begin
                    chk("s_req", 71'(s_bus.req), 71'(c.s_req));
                    if (c.s_req)
                        chk("s_fields", {s_bus.wr, s_bus.size, s_bus.wstrb, s_bus.addr, s_bus.wdata}, c.fields);
                    chk("addr_ok", 71'({inst_bus.addr_ok, data_bus.addr_ok}), 71'({c.iok, c.dok}));
                    chk("resp_err", 71'(resp_err), 71'(c.err));
                    if (inst_bus.data_ok || data_bus.data_ok) begin
                        chk("data_ok_both", 71'(inst_bus.data_ok & data_bus.data_ok), 71'(0));
                        if (rsp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rsp_unexpected: got data_ok inst=%0b data=%0b required none",
                                     inst_bus.data_ok, data_bus.data_ok);
                        end else begin
                            r = rsp_q.pop_front();
                            chk("rsp_src", 71'(data_bus.data_ok), 71'(r.id));
                            chk("rsp_rdata", 71'(r.id ? data_bus.rdata : inst_bus.rdata), 71'(r.rdata));
                        end
                    end
                end
            end
        end
    end

    initial begin : driver
        bit ip, dp, aok, dok;
        reset          = 1'b1;
        inst_bus.req   = 1'b0;
        data_bus.req   = 1'b0;
        s_bus.addr_ok  = 1'b0;
        s_bus.data_ok  = 1'b0;
        s_bus.rdata    = '0;
        set_master(1'b0, 32'h0, 1'b0);
        set_master(1'b1, 32'h0, 1'b0);
        lock  = 0;
        err_m = 1'b0;
        @(negedge clk);
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, ia, da);

        // Simultaneous requests: data wins, inst follows.
        set_master(1'b0, 32'h1C000040, 1'b0);
        set_master(1'b1, 32'h00000200, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, ia, da);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, ia, da);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, ia, da);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0002, ia, da);

        // Grant lock: inst stalls three cycles while data waits.
        set_master(1'b0, 32'h1C000080, 1'b0);
        set_master(1'b1, 32'h00000300, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, ia, da);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, ia, da);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, ia, da);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, ia, da);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, ia, da);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_2222, ia, da);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h3333_4444, ia, da);

        // In-order response routing.
        set_master(1'b0, 32'h1C000000, 1'b0);
        set_master(1'b1, 32'h00000010, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, ia, da);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, ia, da);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h02800000, ia, da);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, ia, da);

        // Full FIFO blocks arbitration, including the cycle of the pop.
        set_master(1'b0, 32'h1C000100, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, ia, da);
        set_master(1'b1, 32'h00000400, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, ia, da);
        set_master(1'b0, 32'h1C000104, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, ia, da);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h5555_0001, ia, da);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, ia, da);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h5555_0002, ia, da);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h5555_0003, ia, da);

        // Orphan response sets the sticky error.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hBAD0_BAD0, ia, da);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, ia, da);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, ia, da);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h7777_0000, ia, da);

        // Reset while holding data with one entry outstanding.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, ia, da);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, ia, da);
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, ia, da);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, ia, da);

        // Randomized traffic, including occasional dropped held requests.
        ip = 1'b0;
        dp = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!ip && $urandom_range(0, 1) == 1) begin
                ip = 1'b1;
                set_master(1'b0, $urandom & 32'hFFFF_FFFC, 1'b0);
            end else if (ip && lock == 1 && $urandom_range(0, 15) == 0) begin
                ip = 1'b0;
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1'b1;
                set_master(1'b1, $urandom, 1'($urandom));
            end else if (dp && lock == 2 && $urandom_range(0, 15) == 0) begin
                dp = 1'b0;
            end
            aok = ($urandom_range(0, 2) != 0);
            dok = (out_q.size() > 0) && ($urandom_range(0, 1) == 1);
            cycle(ip, dp, aok, dok, $urandom, ia, da);
            if (ia) ip = 1'b0;
            if (da) dp = 1'b0;
        end
        for (int n = 0; n < 8; n++) begin
            cycle(1'b0, 1'b0, 1'b0, out_q.size() > 0, $urandom, ia, da);
        end
        #5;
        chk("rsp_left", 71'(rsp_q.size()), 71'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
